// File: rtl/apu_pkg.sv
// Shared APU constants: register addresses, length-counter load table and triangle sequence.
package apu_pkg;

    localparam logic [1:0] ADDR_LINEAR   = 2'd0;
    localparam logic [1:0] ADDR_TIMER_LO = 2'd2;
    localparam logic [1:0] ADDR_TIMER_HI = 2'd3;

    localparam logic [7:0] LENGTH_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    localparam logic [3:0] TRI_SEQ [0:31] = '{
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,  4'd8,
        4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd0,
        4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [3:0] tri_sample(input logic [4:0] step);
        return TRI_SEQ[step];
    endfunction

endpackage

// File: rtl/apu_triangle_if.sv
// CPU register-write bus into an APU channel.
interface apu_triangle_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/apu_length_counter.sv
// Length counter shared by the pulse, triangle and noise channels: table load,
// halt, half-frame decrement and the channel-disable force to zero.
module apu_length_counter
    import apu_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [4:0]       load_idx,
    input  logic             halt,
    input  logic             half_frame,
    output logic [LEN_W-1:0] length
);

    logic [LEN_W-1:0] length_reg;
    logic [LEN_W-1:0] length_next;

    // A load in the same cycle as a half frame wins; the decrement is lost.
    always_comb begin
        length_next = length_reg;
        if (!enable) begin
            length_next = '0;
        end else if (load) begin
            length_next = LEN_W'(LENGTH_TABLE[load_idx]);
        end else if (half_frame && !halt && length_reg != '0) begin
            length_next = length_reg - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            length_reg <= '0;
        end else begin
            length_reg <= length_next;
        end
    end

    assign length = length_reg;

endmodule

// File: rtl/apu_triangle.sv
// NES APU triangle channel: period timer, 32-step sequencer, linear counter and
// length counter, producing the 4-bit sample fed to the mixer.
module apu_triangle
    import apu_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_ce,
    input  logic                 quarter_frame,
    input  logic                 half_frame,
    apu_triangle_if.slave        bus,
    input  logic                 chan_enable,
    output logic [3:0]           tr_out,
    output logic                 length_active
);

    logic        ctrl_reg;
    logic [6:0]  lin_reload_reg;
    logic [6:0]  lin_reg;
    logic        reload_flag_reg;
    logic [10:0] period_reg;
    logic [10:0] timer_reg;
    logic [4:0]  step_reg;
    logic [3:0]  tr_out_reg;

    logic             wr_linear;
    logic             wr_timer_lo;
    logic             wr_timer_hi;
    logic             seq_step_en;
    logic [LEN_W-1:0] length_val;

    assign wr_linear   = bus.wr_en && (bus.wr_addr == ADDR_LINEAR);
    assign wr_timer_lo = bus.wr_en && (bus.wr_addr == ADDR_TIMER_LO);
    assign wr_timer_hi = bus.wr_en && (bus.wr_addr == ADDR_TIMER_HI);

    // Periods below 2 would be ultrasonic; the sequencer parks instead of popping.
    assign seq_step_en = (lin_reg != 7'd0) && (length_val != '0) && (period_reg >= 11'd2);

    apu_length_counter #(
        .LEN_W (LEN_W)
    ) u_length (
        .clk        (clk),
        .rst        (rst),
        .enable     (chan_enable),
        .load       (wr_timer_hi),
        .load_idx   (bus.wr_data[7:3]),
        .halt       (ctrl_reg),
        .half_frame (half_frame),
        .length     (length_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg        <= 1'b0;
            lin_reload_reg  <= 7'd0;
            lin_reg         <= 7'd0;
            reload_flag_reg <= 1'b0;
            period_reg      <= 11'd0;
            timer_reg       <= 11'd0;
            step_reg        <= 5'd0;
            tr_out_reg      <= 4'd15;
        end else begin
            if (wr_linear) begin
                ctrl_reg       <= bus.wr_data[7];
                lin_reload_reg <= bus.wr_data[6:0];
            end
            if (wr_timer_lo) begin
                period_reg[7:0] <= bus.wr_data;
            end
            if (wr_timer_hi) begin
                period_reg[10:8] <= bus.wr_data[2:0];
            end

            if (cpu_ce) begin
                if (timer_reg == 11'd0) begin
                    timer_reg <= period_reg;
                    if (seq_step_en) begin
                        step_reg <= step_reg + 5'd1;
                    end
                end else begin
                    timer_reg <= timer_reg - 11'd1;
                end
            end

            // Quarter frame sees the old flag and old ctrl; a $400B write re-arms the flag last.
            if (quarter_frame) begin
                if (reload_flag_reg) begin
                    lin_reg <= lin_reload_reg;
                end else if (lin_reg != 7'd0) begin
                    lin_reg <= lin_reg - 7'd1;
                end
                if (!ctrl_reg) begin
                    reload_flag_reg <= 1'b0;
                end
            end
            if (wr_timer_hi) begin
                reload_flag_reg <= 1'b1;
            end

            tr_out_reg <= tri_sample(step_reg);
        end
    end

    assign tr_out        = tr_out_reg;
    assign length_active = (length_val != '0);

endmodule
